// File: rtl/lantian_mdio_responder_if.sv
// MDIO pad pins and register-file bus shared by the lantian MDIO responder
// and whatever drives it (the MDIO master side plus the register file).
interface lantian_mdio_responder_if;
   logic        mdc;
   logic        mdio_in;
   logic        mdio_out;
   logic        mdio_oen;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [15:0] reg_rdata;
   logic        frame_err;

   modport slave (
      input  mdc, mdio_in, reg_rdata,
      output mdio_out, mdio_oen, reg_addr, reg_wdata, reg_we, reg_re, frame_err
   );

   modport master (
      output mdc, mdio_in, reg_rdata,
      input  mdio_out, mdio_oen, reg_addr, reg_wdata, reg_we, reg_re, frame_err
   );
endinterface

// File: rtl/lantian_mdio_responder.sv
// Clause-22 MDIO responder oversampling MDC on clk. Optional feature macro:
// MDIO_PREAMBLE_SUPPRESS_EN (any 0 during PREAMBLE starts a frame).
module lantian_mdio_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4:0]                    phy_addr,
   lantian_mdio_responder_if.slave       bus
);

   localparam logic [2:0] ST_PREAMBLE = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_OPCODE   = 3'd2;
   localparam logic [2:0] ST_PHYAD    = 3'd3;
   localparam logic [2:0] ST_REGAD    = 3'd4;
   localparam logic [2:0] ST_TA       = 3'd5;
   localparam logic [2:0] ST_RDATA    = 3'd6;
   localparam logic [2:0] ST_WDATA    = 3'd7;

   localparam logic [5:0] PRE_FULL = 6'd32;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam bit PRE_SUPPRESS = 1'b1;
`else
   localparam bit PRE_SUPPRESS = 1'b0;
`endif

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("SYNC_STAGES must be in the range 2..4");
   end

   logic [SYNC_STAGES-1:0] mdc_sync;
   logic [SYNC_STAGES-1:0] mdio_sync;
   logic                   mdc_prev;
   logic                   mdc_s;
   logic                   mdc_edge;
   logic                   sbit;

   logic [2:0]  state;
   logic [5:0]  pre_cnt;
   logic [4:0]  bit_cnt;
   logic        op_hi;
   logic        is_read;
   logic [3:0]  phy_sh;
   logic [3:0]  addr_sh;
   logic [14:0] wd_sh;
   logic [15:0] rd_sh;
   logic [1:0]  re_d;

   logic        mdio_out_q;
   logic        mdio_oen_q;
   logic [4:0]  reg_addr_q;
   logic [15:0] reg_wdata_q;
   logic        reg_we_q;
   logic        reg_re_q;
   logic        frame_err_q;

   assign mdc_s    = mdc_sync[SYNC_STAGES-1];
   assign sbit     = mdio_sync[SYNC_STAGES-1];
   assign mdc_edge = mdc_s & ~mdc_prev;

   // mdc and mdio_in share the same depth so the sampled bit lines up with the edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         mdc_sync  <= '0;
         mdio_sync <= '0;
         mdc_prev  <= 1'b0;
      end else begin
         mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], bus.mdc};
         mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], bus.mdio_in};
         mdc_prev  <= mdc_s;
      end
   end

   // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: shift registers are reset too, so a frame cut short by reset leaves no stale data.
         state       <= ST_PREAMBLE;
         pre_cnt     <= '0;
         bit_cnt     <= '0;
         op_hi       <= 1'b0;
         is_read     <= 1'b0;
         phy_sh      <= '0;
         addr_sh     <= '0;
         wd_sh       <= '0;
         rd_sh       <= '0;
         re_d        <= '0;
         mdio_out_q  <= 1'b0;
         mdio_oen_q  <= 1'b1;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         frame_err_q <= 1'b0;

         // read data is guaranteed two clk after the strobe
         re_d <= {re_d[0], reg_re_q};
         if (re_d[1]) begin
            rd_sh <= bus.reg_rdata;
         end

         if (mdc_edge) begin
            case (state)
               ST_PREAMBLE: begin
                  if (sbit) begin
                     if (pre_cnt != PRE_FULL) begin
                        pre_cnt <= pre_cnt + 6'd1;
                     end
                  end else begin
                     pre_cnt <= '0;
                     if (pre_cnt == PRE_FULL || PRE_SUPPRESS) begin
                        state <= ST_START;
                     end
                  end
               end

               ST_START: begin
                  if (sbit) begin
                     state   <= ST_OPCODE;
                     bit_cnt <= 5'd1;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= ST_PREAMBLE;
                  end
               end

               ST_OPCODE: begin
                  if (bit_cnt != 5'd0) begin
                     op_hi   <= sbit;
                     bit_cnt <= 5'd0;
                  end else begin
                     case ({op_hi, sbit})
                        2'b10: begin
                           is_read <= 1'b1;
                           state   <= ST_PHYAD;
                           bit_cnt <= 5'd4;
                        end
                        2'b01: begin
                           is_read <= 1'b0;
                           state   <= ST_PHYAD;
                           bit_cnt <= 5'd4;
                        end
                        default: begin
                           frame_err_q <= 1'b1;
                           state       <= ST_PREAMBLE;
                        end
                     endcase
                  end
               end

               ST_PHYAD: begin
                  phy_sh <= {phy_sh[2:0], sbit};
                  if (bit_cnt == 5'd0) begin
                     // frames for other PHYs are dropped without any error
                     if ({phy_sh, sbit} == phy_addr) begin
                        state   <= ST_REGAD;
                        bit_cnt <= 5'd4;
                     end else begin
                        state <= ST_PREAMBLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end

               ST_REGAD: begin
                  addr_sh <= {addr_sh[2:0], sbit};
                  if (bit_cnt == 5'd0) begin
                     reg_addr_q <= {addr_sh, sbit};
                     reg_re_q   <= is_read;
                     state      <= ST_TA;
                     bit_cnt    <= 5'd1;
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end

               ST_TA: begin
                  if (bit_cnt != 5'd0) begin
                     bit_cnt <= 5'd0;
                     if (is_read) begin
                        mdio_oen_q <= 1'b0;
                        mdio_out_q <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= 5'd15;
                     if (is_read) begin
                        mdio_out_q <= rd_sh[15];
                        rd_sh      <= {rd_sh[14:0], 1'b0};
                        state      <= ST_RDATA;
                     end else begin
                        state <= ST_WDATA;
                     end
                  end
               end

               ST_RDATA: begin
                  if (bit_cnt == 5'd0) begin
                     mdio_oen_q <= 1'b1;
                     mdio_out_q <= 1'b0;
                     state      <= ST_PREAMBLE;
                  end else begin
                     mdio_out_q <= rd_sh[15];
                     rd_sh      <= {rd_sh[14:0], 1'b0};
                     bit_cnt    <= bit_cnt - 5'd1;
                  end
               end

               ST_WDATA: begin
                  wd_sh <= {wd_sh[13:0], sbit};
                  if (bit_cnt == 5'd0) begin
                     reg_wdata_q <= {wd_sh, sbit};
                     reg_we_q    <= 1'b1;
                     state       <= ST_PREAMBLE;
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end

               default: begin
                  mdio_oen_q <= 1'b1;
                  state      <= ST_PREAMBLE;
               end
            endcase
         end
      end
   end

   assign bus.mdio_out  = mdio_out_q;
   assign bus.mdio_oen  = mdio_oen_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_re    = reg_re_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_lantian_mdio_responder.sv
// Directed, table-driven bench for lantian_mdio_responder: whole MDIO frames
// per table row plus hand sequences for reset and back-to-back corners.
module tb_lantian_mdio_responder;

   localparam int HALF = 6;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam bit SUPPRESS = 1'b1;
`else
   localparam bit SUPPRESS = 1'b0;
`endif
   localparam logic [4:0] HOLD_ADDR = SUPPRESS ? 5'h06 : 5'h04;

   typedef struct {
      int          pre;
      logic [1:0]  st;
      logic [1:0]  op;
      logic [4:0]  dut_phy;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] wd;
      logic [15:0] rd;
      int          e_re;
      int          e_we;
      int          e_err;
      bit          e_drive;
      logic [4:0]  e_addr;
      logic [15:0] e_wdata;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] phy_addr;

   lantian_mdio_responder_if bus();

   lantian_mdio_responder #(.SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .phy_addr (phy_addr),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int re_cnt   = 0;
   int we_cnt   = 0;
   int err_cnt  = 0;
   int oen_cnt  = 0;
   int both_cnt = 0;

   always @(negedge clk) begin
      if (bus.reg_re === 1'b1)                        re_cnt   <= re_cnt + 1;
      if (bus.reg_we === 1'b1)                        we_cnt   <= we_cnt + 1;
      if (bus.frame_err === 1'b1)                     err_cnt  <= err_cnt + 1;
      if (bus.mdio_oen === 1'b0)                      oen_cnt  <= oen_cnt + 1;
      if (bus.reg_re === 1'b1 && bus.reg_we === 1'b1) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one MDC period; called and returns at 1 time unit after a clk rise
   task automatic send_bit(input logic b);
      bus.mdc     = 1'b0;
      bus.mdio_in = b;
      repeat (HALF) @(posedge clk);
      #1;
      bus.mdc = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic send_header(input vec_t v);
      for (int i = 0; i < v.pre; i++) send_bit(1'b1);
      send_bit(v.st[1]);
      send_bit(v.st[0]);
      send_bit(v.op[1]);
      send_bit(v.op[0]);
      for (int i = 4; i >= 0; i--) send_bit(v.phy[i]);
      for (int i = 4; i >= 0; i--) send_bit(v.ra[i]);
   endtask

   task automatic run_frame(input vec_t v, input string name);
      int          r0, w0, e0, o0;
      logic [15:0] word;
      bit          ta_ok, drive_ok, rel_ok;
      phy_addr      = v.dut_phy;
      bus.reg_rdata = v.rd;
      r0 = re_cnt; w0 = we_cnt; e0 = err_cnt; o0 = oen_cnt;
      word = '0; ta_ok = 1'b0; drive_ok = 1'b1; rel_ok = 1'b0;
      send_header(v);
      if (v.op == 2'b01) begin
         send_bit(1'b1);
         send_bit(1'b0);
         for (int i = 15; i >= 0; i--) send_bit(v.wd[i]);
      end else begin
         for (int k = 0; k < 18; k++) begin
            send_bit(1'b1);
            if (k == 0) ta_ok = (bus.mdio_oen === 1'b0) && (bus.mdio_out === 1'b0);
            else if (k <= 16) begin
               word[16-k] = bus.mdio_out;
               if (bus.mdio_oen !== 1'b0) drive_ok = 1'b0;
            end else rel_ok = (bus.mdio_oen === 1'b1);
         end
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, " reg_re pulses"},  re_cnt - r0,  v.e_re);
      check({name, " reg_we pulses"},  we_cnt - w0,  v.e_we);
      check({name, " frame_err"},      err_cnt - e0, v.e_err);
      check({name, " drove mdio"},     (oen_cnt - o0) != 0, v.e_drive);
      check({name, " reg_addr"},       bus.reg_addr,  v.e_addr);
      check({name, " reg_wdata"},      bus.reg_wdata, v.e_wdata);
      if (v.e_drive) begin
         check({name, " ta drive 0"},   ta_ok,    1'b1);
         check({name, " data oen low"}, drive_ok, 1'b1);
         check({name, " read word"},    word,     v.rd);
         check({name, " release"},      rel_ok,   1'b1);
      end
   endtask

   vec_t vecs[10];

   initial begin
      int r0;
      vec_t hv;

      vecs[0] = '{32, 2'b01, 2'b10, 5'h03, 5'h03, 5'h02, 16'h0000, 16'hA5C3, 1, 0, 0, 1'b1, 5'h02, 16'h0000};
      vecs[1] = '{32, 2'b01, 2'b01, 5'h03, 5'h03, 5'h04, 16'h1234, 16'h0000, 0, 1, 0, 1'b0, 5'h04, 16'h1234};
      vecs[2] = '{20, 2'b01, 2'b10, 5'h03, 5'h03, 5'h06, 16'h0000, 16'h0F0F,
                  SUPPRESS ? 1 : 0, 0, 0, SUPPRESS, HOLD_ADDR, 16'h1234};
      vecs[3] = '{32, 2'b01, 2'b10, 5'h03, 5'h07, 5'h1F, 16'h0000, 16'hFFFF, 0, 0, 0, 1'b0, HOLD_ADDR, 16'h1234};
      vecs[4] = '{32, 2'b01, 2'b11, 5'h03, 5'h1F, 5'h1F, 16'h0000, 16'h0000, 0, 0, 1, 1'b0, HOLD_ADDR, 16'h1234};
      vecs[5] = '{32, 2'b00, 2'b11, 5'h03, 5'h1F, 5'h1F, 16'h0000, 16'h0000, 0, 0, 1, 1'b0, HOLD_ADDR, 16'h1234};
      vecs[6] = '{32, 2'b01, 2'b01, 5'h03, 5'h03, 5'h00, 16'hFFFF, 16'h0000, 0, 1, 0, 1'b0, 5'h00, 16'hFFFF};
      vecs[7] = '{32, 2'b01, 2'b10, 5'h03, 5'h03, 5'h1F, 16'h0000, 16'h8001, 1, 0, 0, 1'b1, 5'h1F, 16'hFFFF};
      vecs[8] = '{32, 2'b01, 2'b10, 5'h1C, 5'h1C, 5'h0A, 16'h0000, 16'h5A5A, 1, 0, 0, 1'b1, 5'h0A, 16'hFFFF};
      vecs[9] = '{32, 2'b01, 2'b01, 5'h1C, 5'h1C, 5'h15, 16'h0001, 16'h0000, 0, 1, 0, 1'b0, 5'h15, 16'h0001};

      reset         = 1'b0;
      bus.mdc       = 1'b0;
      bus.mdio_in   = 1'b1;
      bus.reg_rdata = 16'h0000;
      phy_addr      = 5'h03;
      repeat (3) @(posedge clk);
      #1;
      check("reset mdio_oen",  bus.mdio_oen,  1'b1);
      check("reset mdio_out",  bus.mdio_out,  1'b0);
      check("reset reg_addr",  bus.reg_addr,  5'h00);
      check("reset reg_wdata", bus.reg_wdata, 16'h0000);
      check("reset reg_we",    bus.reg_we,    1'b0);
      check("reset reg_re",    bus.reg_re,    1'b0);
      check("reset frame_err", bus.frame_err, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // write immediately followed by a read with no preamble
      hv = '{32, 2'b01, 2'b01, 5'h03, 5'h03, 5'h02, 16'hBEEF, 16'h0000, 0, 1, 0, 1'b0, 5'h02, 16'hBEEF};
      run_frame(hv, "b2b write");
      hv = '{0, 2'b01, 2'b10, 5'h03, 5'h03, 5'h02, 16'h0000, 16'hC3A5,
             SUPPRESS ? 1 : 0, 0, 0, SUPPRESS, 5'h02, 16'hBEEF};
      run_frame(hv, "b2b read");

      // reset asserted while data bit 7 of a read is on the line
      phy_addr      = 5'h03;
      bus.reg_rdata = 16'h6DAB;
      hv = '{32, 2'b01, 2'b10, 5'h03, 5'h03, 5'h05, 16'h0000, 16'h6DAB, 1, 0, 0, 1'b1, 5'h05, 16'h0000};
      send_header(hv);
      for (int k = 0; k < 10; k++) send_bit(1'b1);
      check("mid-read bit7 driven", {bus.mdio_oen, bus.mdio_out}, 2'b01);
      reset   = 1'b0;
      bus.mdc = 1'b0;
      @(posedge clk);
      #1;
      check("mid-read reset oen",  bus.mdio_oen, 1'b1);
      check("mid-read reset out",  bus.mdio_out, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("mid-read reset addr", bus.reg_addr, 5'h00);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // a full frame right after reset must be decoded from PREAMBLE
      hv = '{32, 2'b01, 2'b10, 5'h03, 5'h03, 5'h11, 16'h0000, 16'h3C96, 1, 0, 0, 1'b1, 5'h11, 16'h0000};
      run_frame(hv, "post-reset read");

      // reset lands on the clk that would have issued reg_re
      r0 = re_cnt;
      bus.reg_rdata = 16'h0000;
      hv = '{32, 2'b01, 2'b10, 5'h03, 5'h03, 5'h13, 16'h0000, 16'h0000, 0, 0, 0, 1'b0, 5'h00, 16'h0000};
      for (int i = 0; i < 32; i++) send_bit(1'b1);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      for (int i = 4; i >= 0; i--) send_bit(hv.phy[i]);
      for (int i = 4; i >= 1; i--) send_bit(hv.ra[i]);
      bus.mdc     = 1'b0;
      bus.mdio_in = hv.ra[0];
      repeat (HALF) @(posedge clk);
      #1;
      bus.mdc = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("suppressed reg_re",   re_cnt - r0,  0);
      check("suppressed reg_addr", bus.reg_addr, 5'h00);
      check("suppressed oen",      bus.mdio_oen, 1'b1);
      bus.mdc = 1'b0;
      reset   = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      check("reg_re/reg_we overlap", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
